// File: rtl/dica_menor_maior_multi_if.sv
// Switch/button side and display side of the multi-stage hint unit, bundled for dica_menor_maior_multi.
// master = the driver of guesses and secrets, slave = the hint unit itself.
interface dica_menor_maior_multi_if #(
  parameter int WIDTH     = 4,
  parameter int N_STAGES  = 2,
  parameter int MAX_TRIES = 7
);
  localparam int STAGE_W = $clog2(N_STAGES + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);

  logic                      ENABLE;
  logic                      ENTER;
  logic [WIDTH-1:0]          TENTATIVA;
  logic [N_STAGES*WIDTH-1:0] SENHAS;
  logic [0:6]                MENOR_OU_MAIOR;
  logic [STAGE_W-1:0]        STAGE;
  logic                      ACERTOU;
  logic [TRY_W-1:0]          TENTATIVAS_RESTANTES;
  logic                      DESARMADO;
  logic                      EXPLODIU;

  modport master (
    output ENABLE, ENTER, TENTATIVA, SENHAS,
    input  MENOR_OU_MAIOR, STAGE, ACERTOU, TENTATIVAS_RESTANTES, DESARMADO, EXPLODIU
  );

  modport slave (
    input  ENABLE, ENTER, TENTATIVA, SENHAS,
    output MENOR_OU_MAIOR, STAGE, ACERTOU, TENTATIVAS_RESTANTES, DESARMADO, EXPLODIU
  );
endinterface

// File: rtl/dica_menor_maior_multi.sv
// Multi-stage higher/lower hint FSM; ENTER edge -> outputs in 2 cycles; edges during evaluation,
// with ENABLE low, or after DESARMADO/EXPLODIU are dropped. Optional macro: DICA_PROXIMIDADE_EN.
module dica_menor_maior_multi #(
  parameter int WIDTH     = 4,
  parameter int N_STAGES  = 2,
  parameter int MAX_TRIES = 7,
  parameter int STAGE_W   = $clog2(N_STAGES + 1),
  parameter int TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic CLOCK,
  input  logic RESET,
  dica_menor_maior_multi_if.slave bus
);

  localparam logic [0:6] GLYPH_BLANK = 7'b1111111;
  localparam logic [0:6] GLYPH_HIGH  = 7'b1111001;
  localparam logic [0:6] GLYPH_LOW   = 7'b1001111;

  typedef enum logic [1:0] {ARMADO, AVALIA, DESARMADO_S, EXPLODIDO} state_t;

  state_t             state;
  logic               ent_q;
  logic [WIDTH-1:0]   guess_r;
  logic [WIDTH-1:0]   secret_cur;
  logic [0:6]         glyph_r;
  logic [0:6]         glyph_eval;
  logic [STAGE_W-1:0] stage_r;
  logic [TRY_W-1:0]   tries_r;
  logic               acertou_r;
  logic               desarmado_r;
  logic               explodiu_r;
  logic               enter_edge;
  logic               guess_gt;
  logic               guess_lt;

  assign enter_edge = bus.ENTER & ~ent_q;
  assign guess_gt   = guess_r > secret_cur;
  assign guess_lt   = guess_r < secret_cur;

  always_comb begin
    secret_cur = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      if (stage_r == STAGE_W'(k))
        secret_cur = bus.SENHAS[k*WIDTH +: WIDTH];
    end
  end

`ifdef DICA_PROXIMIDADE_EN
  // One extra bit keeps 0 vs all-ones from wrapping into a distance of 1.
  logic [WIDTH:0] diff_up;
  logic [WIDTH:0] diff_dn;
  assign diff_up = {1'b0, guess_r} - {1'b0, secret_cur};
  assign diff_dn = {1'b0, secret_cur} - {1'b0, guess_r};
`endif

  always_comb begin
    glyph_eval = GLYPH_BLANK;
    if (guess_gt)
      glyph_eval = GLYPH_HIGH;
    else if (guess_lt)
      glyph_eval = GLYPH_LOW;
`ifdef DICA_PROXIMIDADE_EN
    if (guess_gt && diff_up == (WIDTH+1)'(1))
      glyph_eval = 7'b0111001;
    else if (guess_lt && diff_dn == (WIDTH+1)'(1))
      glyph_eval = 7'b0001111;
`endif
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= ARMADO;
      ent_q       <= 1'b1;
      guess_r     <= '0;
      glyph_r     <= GLYPH_BLANK;
      stage_r     <= '0;
      tries_r     <= TRY_W'(MAX_TRIES);
      acertou_r   <= 1'b0;
      desarmado_r <= 1'b0;
      explodiu_r  <= 1'b0;
    end else begin
      ent_q     <= bus.ENTER;
      acertou_r <= 1'b0;
      case (state)
        ARMADO: begin
          if (enter_edge && bus.ENABLE) begin
            guess_r <= bus.TENTATIVA;
            state   <= AVALIA;
          end
        end
        AVALIA: begin
          glyph_r <= glyph_eval;
          if (guess_gt || guess_lt) begin
            // A zero count is only ever reached together with the move to EXPLODIDO.
            if (tries_r != '0)
              tries_r <= tries_r - TRY_W'(1);
            if (tries_r <= TRY_W'(1)) begin
              explodiu_r <= 1'b1;
              state      <= EXPLODIDO;
            end else begin
              state <= ARMADO;
            end
          end else begin
            acertou_r <= 1'b1;
            stage_r   <= stage_r + STAGE_W'(1);
            if (stage_r == STAGE_W'(N_STAGES - 1)) begin
              desarmado_r <= 1'b1;
              state       <= DESARMADO_S;
            end else begin
              state <= ARMADO;
            end
          end
        end
        DESARMADO_S: state <= DESARMADO_S;
        EXPLODIDO:   state <= EXPLODIDO;
        default:     state <= ARMADO;
      endcase
    end
  end

  assign bus.MENOR_OU_MAIOR       = glyph_r;
  assign bus.STAGE                = stage_r;
  assign bus.ACERTOU              = acertou_r;
  assign bus.TENTATIVAS_RESTANTES = tries_r;
  assign bus.DESARMADO            = desarmado_r;
  assign bus.EXPLODIU             = explodiu_r;

endmodule

// File: tb/tb_dica_menor_maior_multi.sv
// Directed bench: a default unit (2 stages, 7 tries) and a 1-stage, 2-try unit side by side.
module tb_dica_menor_maior_multi;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dica_menor_maior_multi_if #(.WIDTH(4), .N_STAGES(2), .MAX_TRIES(7)) ifa ();
  dica_menor_maior_multi_if #(.WIDTH(4), .N_STAGES(1), .MAX_TRIES(2)) ifb ();

  dica_menor_maior_multi #(.WIDTH(4), .N_STAGES(2), .MAX_TRIES(7)) dut_a (
    .CLOCK (clk),
    .RESET (rst_a),
    .bus   (ifa.slave)
  );

  dica_menor_maior_multi #(.WIDTH(4), .N_STAGES(1), .MAX_TRIES(2)) dut_b (
    .CLOCK (clk),
    .RESET (rst_b),
    .bus   (ifb.slave)
  );

  localparam logic [31:0] G_BLANK = 32'h7F;
  localparam logic [31:0] G_HIGH  = 32'h79;
  localparam logic [31:0] G_LOW   = 32'h4F;
`ifdef DICA_PROXIMIDADE_EN
  localparam logic [31:0] G_HIGH_CLOSE = 32'h39;
  localparam logic [31:0] G_LOW_CLOSE  = 32'h0F;
`else
  localparam logic [31:0] G_HIGH_CLOSE = 32'h79;
  localparam logic [31:0] G_LOW_CLOSE  = 32'h4F;
`endif

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge taken on the first posedge, evaluated on the second; outputs readable afterwards.
  task automatic press_a(input logic [3:0] g);
    ifa.TENTATIVA = g;
    ifa.ENTER     = 1'b1;
    step(1);
    ifa.ENTER     = 1'b0;
    step(1);
  endtask

  task automatic press_b(input logic [3:0] g);
    ifb.TENTATIVA = g;
    ifb.ENTER     = 1'b1;
    step(1);
    ifb.ENTER     = 1'b0;
    step(1);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.ENABLE = 1'b1; ifa.ENTER = 1'b1; ifa.TENTATIVA = 4'd0; ifa.SENHAS = {4'd9, 4'd5};
    ifb.ENABLE = 1'b1; ifb.ENTER = 1'b0; ifb.TENTATIVA = 4'd0; ifb.SENHAS = 4'd0;
    step(3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step(3);

    // ENTER held through reset release is not a submit
    check("rst_glyph", 32'(ifa.MENOR_OU_MAIOR), G_BLANK);
    check("rst_tries", 32'(ifa.TENTATIVAS_RESTANTES), 32'd7);
    check("rst_stage", 32'(ifa.STAGE), 32'd0);
    check("rst_flags", {29'd0, ifa.ACERTOU, ifa.DESARMADO, ifa.EXPLODIU}, 32'd0);
    ifa.ENTER = 1'b0;
    step(1);

    // latency: nothing visible one cycle after the edge
    ifa.TENTATIVA = 4'd8;
    ifa.ENTER     = 1'b1;
    step(1);
    check("lat_glyph_t1", 32'(ifa.MENOR_OU_MAIOR), G_BLANK);
    check("lat_tries_t1", 32'(ifa.TENTATIVAS_RESTANTES), 32'd7);
    ifa.ENTER = 1'b0;
    step(1);
    check("hi_glyph", 32'(ifa.MENOR_OU_MAIOR), G_HIGH);
    check("hi_tries", 32'(ifa.TENTATIVAS_RESTANTES), 32'd6);

    press_a(4'd2);
    check("lo_glyph", 32'(ifa.MENOR_OU_MAIOR), G_LOW);
    check("lo_tries", 32'(ifa.TENTATIVAS_RESTANTES), 32'd5);

    ifa.ENABLE = 1'b0;
    press_a(4'd8);
    step(1);
    check("dis_glyph", 32'(ifa.MENOR_OU_MAIOR), G_LOW);
    check("dis_tries", 32'(ifa.TENTATIVAS_RESTANTES), 32'd5);
    ifa.ENABLE = 1'b1;

    // button stays down across evaluation: only one guess counted
    ifa.TENTATIVA = 4'd8;
    ifa.ENTER     = 1'b1;
    step(3);
    ifa.ENTER = 1'b0;
    step(1);
    check("drop_tries", 32'(ifa.TENTATIVAS_RESTANTES), 32'd4);
    check("drop_glyph", 32'(ifa.MENOR_OU_MAIOR), G_HIGH);

    press_a(4'd6);
    check("near_hi", 32'(ifa.MENOR_OU_MAIOR), G_HIGH_CLOSE);
    press_a(4'd4);
    check("near_lo", 32'(ifa.MENOR_OU_MAIOR), G_LOW_CLOSE);
    press_a(4'd7);
    check("far_hi", 32'(ifa.MENOR_OU_MAIOR), G_HIGH);
    check("near_tries", 32'(ifa.TENTATIVAS_RESTANTES), 32'd1);

    press_a(4'd5);
    check("ok0_pulse", 32'(ifa.ACERTOU), 32'd1);
    check("ok0_glyph", 32'(ifa.MENOR_OU_MAIOR), G_BLANK);
    check("ok0_stage", 32'(ifa.STAGE), 32'd1);
    step(1);
    check("ok0_pulse_end", 32'(ifa.ACERTOU), 32'd0);

    press_a(4'd9);
    check("ok1_pulse", 32'(ifa.ACERTOU), 32'd1);
    check("ok1_stage", 32'(ifa.STAGE), 32'd2);
    check("ok1_desarm", 32'(ifa.DESARMADO), 32'd1);
    check("ok1_tries", 32'(ifa.TENTATIVAS_RESTANTES), 32'd1);
    press_a(4'd3);
    step(1);
    check("term_glyph", 32'(ifa.MENOR_OU_MAIOR), G_BLANK);
    check("term_flags", {29'd0, ifa.ACERTOU, ifa.DESARMADO, ifa.EXPLODIU}, 32'd2);
    check("term_stage", 32'(ifa.STAGE), 32'd2);

    // reset arriving while a guess is being evaluated
    rst_a = 1'b1;
    step(2);
    rst_a = 1'b0;
    step(1);
    press_a(4'd8);
    check("rearm_tries", 32'(ifa.TENTATIVAS_RESTANTES), 32'd6);
    ifa.TENTATIVA = 4'd2;
    ifa.ENTER     = 1'b1;
    step(1);
    rst_a     = 1'b1;
    ifa.ENTER = 1'b0;
    step(1);
    rst_a = 1'b0;
    check("mid_rst_glyph", 32'(ifa.MENOR_OU_MAIOR), G_BLANK);
    check("mid_rst_tries", 32'(ifa.TENTATIVAS_RESTANTES), 32'd7);
    check("mid_rst_stage", 32'(ifa.STAGE), 32'd0);
    check("mid_rst_flags", {29'd0, ifa.ACERTOU, ifa.DESARMADO, ifa.EXPLODIU}, 32'd0);

    // unit B: secret 0, two tries; 15 vs 0 must not count as close
    check("b_rst_tries", 32'(ifb.TENTATIVAS_RESTANTES), 32'd2);
    press_b(4'd15);
    check("b_wrap_glyph", 32'(ifb.MENOR_OU_MAIOR), G_HIGH);
    check("b_tries1", 32'(ifb.TENTATIVAS_RESTANTES), 32'd1);
    check("b_not_expl", 32'(ifb.EXPLODIU), 32'd0);
    press_b(4'd1);
    check("b_near_glyph", 32'(ifb.MENOR_OU_MAIOR), G_HIGH_CLOSE);
    check("b_tries0", 32'(ifb.TENTATIVAS_RESTANTES), 32'd0);
    check("b_expl", 32'(ifb.EXPLODIU), 32'd1);
    press_b(4'd0);
    check("b_late_pulse", 32'(ifb.ACERTOU), 32'd0);
    check("b_late_stage", 32'(ifb.STAGE), 32'd0);
    check("b_late_glyph", 32'(ifb.MENOR_OU_MAIOR), G_HIGH_CLOSE);
    check("b_late_flags", {30'd0, ifb.DESARMADO, ifb.EXPLODIU}, 32'd1);
    check("b_late_tries", 32'(ifb.TENTATIVAS_RESTANTES), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
